// File: rtl/systolic_os_array.sv
// Output-stationary systolic array: C = A x B, with A columns and B rows streamed
// over the inner dimension K. Each PE(i,j) owns accumulator C[i][j]; operands are
// skewed on entry so matching pairs meet in every PE. Results drain one row per
// handshake.
module systolic_os_array #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 2 * DATA_W + 8,
  parameter int unsigned K_W      = 10,
  parameter int unsigned SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_W-1:0]            k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_W-1:0]    a_vec,
  input  logic [COLS*DATA_W-1:0]    b_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_W-1:0]     out_vec,
  output logic [$clog2(ROWS)-1:0]   out_row,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned RW        = $clog2(ROWS);
  localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
  localparam int unsigned FW        = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] k_q, beat_q;
  logic [FW-1:0]  flush_q;
  logic [RW-1:0]  row_q;
  logic           done_q;

  logic inject;     // an accepted beat enters the skew lines this cycle
  logic clear_acc;  // accepted start wipes every accumulator
  logic last_beat;

  // Skew lines: row i uses stages 0..i, column j uses stages 0..j.
  logic [DATA_W-1:0] a_sk_q  [ROWS][ROWS];
  logic              a_skv_q [ROWS][ROWS];
  logic [DATA_W-1:0] b_sk_q  [COLS][COLS];
  logic              b_skv_q [COLS][COLS];

  // Inter-PE forwarding registers: a moves right, b moves down.
  logic [DATA_W-1:0] a_h_q  [ROWS][COLS-1];
  logic              a_hv_q [ROWS][COLS-1];
  logic [DATA_W-1:0] b_h_q  [ROWS-1][COLS];
  logic              b_hv_q [ROWS-1][COLS];

  // Operands seen by each PE in the current cycle.
  logic [DATA_W-1:0] a_op [ROWS][COLS];
  logic              a_ov [ROWS][COLS];
  logic [DATA_W-1:0] b_op [ROWS][COLS];
  logic              b_ov [ROWS][COLS];

  logic [ACC_W-1:0] acc_q [ROWS][COLS];
  logic [ACC_W-1:0] acc_d [ROWS][COLS];

  // Sign-extended product added to the accumulator, optionally clamped.
  function automatic logic [ACC_W-1:0] mac_step(input logic [ACC_W-1:0]  acc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W:0]             sum;
    prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    sum  = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
    if (SATURATE != 0 && sum[ACC_W] != sum[ACC_W-1]) begin
      mac_step = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      mac_step = sum[ACC_W-1:0];
    end
  endfunction

  assign inject    = (state_q == StFeed) && in_valid;
  assign clear_acc = (state_q == StIdle) && start;
  assign last_beat = inject && ((beat_q + K_W'(1)) == k_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (k_len == '0) ? StDrain : StFeed;
      StFeed:  if (last_beat) state_d = StFlush;
      StFlush: if (flush_q == FW'(FLUSH_LEN - 1)) state_d = StDrain;
      StDrain: if (out_ready && row_q == RW'(ROWS - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == StFeed);
    out_valid = (state_q == StDrain);
    busy      = (state_q != StIdle);
    done      = done_q;
    out_row   = row_q;
  end

  // Tile length, beat/flush/row counters and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            k_q    <= k_len;
            beat_q <= '0;
            row_q  <= '0;
          end
        end
        StFeed: begin
          flush_q <= '0;
          if (in_valid) beat_q <= beat_q + K_W'(1);
        end
        StFlush: flush_q <= flush_q + FW'(1);
        StDrain: begin
          if (out_ready) begin
            if (row_q == RW'(ROWS - 1)) begin
              row_q  <= '0;
              done_q <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand routing: column 0 / row 0 read the skew-line tails, others their neighbour.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_op[i][0] = a_sk_q[i][i];
      a_ov[i][0] = a_skv_q[i][i];
      for (int j = 1; j < COLS; j++) begin
        a_op[i][j] = a_h_q[i][j-1];
        a_ov[i][j] = a_hv_q[i][j-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      b_op[0][j] = b_sk_q[j][j];
      b_ov[0][j] = b_skv_q[j][j];
      for (int i = 1; i < ROWS; i++) begin
        b_op[i][j] = b_h_q[i-1][j];
        b_ov[i][j] = b_hv_q[i-1][j];
      end
    end
  end

  // Accumulator next value; a PE only updates when both operands are valid.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        acc_d[i][j] = acc_q[i][j];
        if (clear_acc) begin
          acc_d[i][j] = '0;
        end else if (a_ov[i][j] && b_ov[i][j]) begin
          acc_d[i][j] = mac_step(acc_q[i][j], a_op[i][j], b_op[i][j]);
        end
      end
    end
  end

  // Datapath registers: the array advances every cycle; bubbles carry zero data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int s = 0; s < ROWS; s++) begin
          a_sk_q[i][s]  <= '0;
          a_skv_q[i][s] <= 1'b0;
        end
        for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
        for (int j = 0; j < COLS - 1; j++) begin
          a_h_q[i][j]  <= '0;
          a_hv_q[i][j] <= 1'b0;
        end
      end
      for (int j = 0; j < COLS; j++) begin
        for (int s = 0; s < COLS; s++) begin
          b_sk_q[j][s]  <= '0;
          b_skv_q[j][s] <= 1'b0;
        end
        for (int i = 0; i < ROWS - 1; i++) begin
          b_h_q[i][j]  <= '0;
          b_hv_q[i][j] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        a_sk_q[i][0]  <= inject ? a_vec[i*DATA_W +: DATA_W] : '0;
        a_skv_q[i][0] <= inject;
        for (int s = 1; s < ROWS; s++) begin
          a_sk_q[i][s]  <= a_sk_q[i][s-1];
          a_skv_q[i][s] <= a_skv_q[i][s-1];
        end
        for (int j = 0; j < COLS - 1; j++) begin
          a_h_q[i][j]  <= a_op[i][j];
          a_hv_q[i][j] <= a_ov[i][j];
        end
        for (int j = 0; j < COLS; j++) acc_q[i][j] <= acc_d[i][j];
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk_q[j][0]  <= inject ? b_vec[j*DATA_W +: DATA_W] : '0;
        b_skv_q[j][0] <= inject;
        for (int s = 1; s < COLS; s++) begin
          b_sk_q[j][s]  <= b_sk_q[j][s-1];
          b_skv_q[j][s] <= b_skv_q[j][s-1];
        end
        for (int i = 0; i < ROWS - 1; i++) begin
          b_h_q[i][j]  <= b_op[i][j];
          b_hv_q[i][j] <= b_ov[i][j];
        end
      end
    end
  end

  // Present the selected accumulator row only while draining.
  always_comb begin
    out_vec = '0;
    if (state_q == StDrain) begin
      for (int j = 0; j < COLS; j++) out_vec[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end
  end

endmodule

// File: tb/tb_systolic_os_array.sv
// Bench for systolic_os_array: three 4x4 instances share one stimulus stream
// (24-bit wrap, 16-bit saturate, 16-bit wrap) and are checked against a
// matrix-product reference model.
module tb_systolic_os_array;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int KW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [R*DW-1:0] a_vec = '0;
  logic [C*DW-1:0] b_vec = '0;

  logic in_ready_w, in_ready_s, in_ready_p;
  logic out_valid_w, out_valid_s, out_valid_p;
  logic [C*24-1:0] vec_w;
  logic [C*16-1:0] vec_s, vec_p;
  logic [1:0] row_w, row_s, row_p;
  logic busy_w, busy_s, busy_p;
  logic done_w, done_s, done_p;

  int total = 0;
  int bad = 0;

  int a_m[64][R];
  int b_m[64][C];
  longint got[3][R][C];
  int got_row[3][R];
  int rows_got;
  logic [2:0] done_now;

  always #5 clk = ~clk;

  systolic_os_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(24), .K_W(KW), .SATURATE(0))
  u_wide (.clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
          .in_ready(in_ready_w), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_w),
          .out_ready(out_ready), .out_vec(vec_w), .out_row(row_w), .busy(busy_w),
          .done(done_w));

  systolic_os_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16), .K_W(KW), .SATURATE(1))
  u_sat (.clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
         .in_ready(in_ready_s), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_s),
         .out_ready(out_ready), .out_vec(vec_s), .out_row(row_s), .busy(busy_s),
         .done(done_s));

  systolic_os_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16), .K_W(KW), .SATURATE(0))
  u_wrap (.clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
          .in_ready(in_ready_p), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_p),
          .out_ready(out_ready), .out_vec(vec_p), .out_row(row_p), .busy(busy_p),
          .done(done_p));

  // Reference: C[i][j] = sum_k A[k][i]*B[k][j], clamped per beat or wrapped at the end.
  function automatic longint model(input int i, input int j, input int k,
                                   input int acc_w, input bit sat);
    longint s, hi, lo;
    s  = 0;
    hi = (longint'(1) << (acc_w - 1)) - 1;
    lo = -(longint'(1) << (acc_w - 1));
    for (int t = 0; t < k; t++) begin
      s = s + longint'(a_m[t][i]) * longint'(b_m[t][j]);
      if (sat) begin
        if (s > hi) s = hi;
        if (s < lo) s = lo;
      end
    end
    if (!sat) begin
      s = s & ((longint'(1) << acc_w) - 1);
      if (s > hi) s = s - (longint'(1) << acc_w);
    end
    return s;
  endfunction

  function automatic longint exp_d(input int d, input int i, input int j, input int k);
    case (d)
      0:       return model(i, j, k, 24, 1'b0);
      1:       return model(i, j, k, 16, 1'b1);
      default: return model(i, j, k, 16, 1'b0);
    endcase
  endfunction

  function automatic longint get_elem(input int d, input int j);
    case (d)
      0:       return longint'($signed(vec_w[j*24 +: 24]));
      1:       return longint'($signed(vec_s[j*16 +: 16]));
      default: return longint'($signed(vec_p[j*16 +: 16]));
    endcase
  endfunction

  function automatic int get_row(input int d);
    case (d)
      0:       return int'(row_w);
      1:       return int'(row_s);
      default: return int'(row_p);
    endcase
  endfunction

  task automatic fill_random(input int k);
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < R; i++) a_m[t][i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < C; j++) b_m[t][j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fill_const(input int k, input int av, input int bv);
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < R; i++) a_m[t][i] = av;
      for (int j = 0; j < C; j++) b_m[t][j] = bv;
    end
  endtask

  // Called at a negedge; returns at the negedge after start is sampled.
  task automatic start_tile(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
  endtask

  // vmode: 0 contiguous, 1 random gaps, 2 fixed 1,0,0,1,1,0,1 pattern.
  task automatic feed(input int k, input int vmode, input int start_at);
    int n, cyc;
    bit v;
    bit pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    n = 0;
    cyc = 0;
    while (n < k && cyc < 5000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = pat[cyc % 7];
      endcase
      in_valid = v;
      start = (start_at >= 0 && n == start_at);
      if (start) k_len = KW'($urandom_range(1, 9));
      if (v) begin
        for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = DW'(a_m[n][i]);
        for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = DW'(b_m[n][j]);
      end else begin
        a_vec = $urandom;
        b_vec = $urandom;
      end
      if (v && in_ready_w) n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (n < k) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: accepted %0d beats, required %0d", n, k);
    end
  endtask

  // rmode: 0 always ready, 1 random ready. noise drives junk input beats meanwhile.
  task automatic drain(input int rmode, input bit noise);
    int cyc;
    bit rdy;
    cyc = 0;
    rows_got = 0;
    for (int d = 0; d < 3; d++) for (int r = 0; r < R; r++) got_row[d][r] = -1;
    while (rows_got < R && cyc < 2000) begin
      rdy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      out_ready = rdy;
      if (noise) begin
        in_valid = $urandom_range(0, 1) != 0;
        a_vec = $urandom;
        b_vec = $urandom;
      end
      if (out_valid_w && rdy) begin
        for (int d = 0; d < 3; d++) begin
          got_row[d][rows_got] = get_row(d);
          for (int j = 0; j < C; j++) got[d][rows_got][j] = get_elem(d, j);
        end
        rows_got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    done_now = {done_w, done_s, done_p};
    if (rows_got < R) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d rows, required %0d", rows_got, R);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready_w, in_ready_s, in_ready_p} !== 3'b000) begin
      bad++; $display("FAIL reset_in_ready: got %b required 000", {in_ready_w, in_ready_s, in_ready_p});
    end
    total++;
    if ({out_valid_w, out_valid_s, out_valid_p} !== 3'b000) begin
      bad++; $display("FAIL reset_out_valid: got %b required 000", {out_valid_w, out_valid_s, out_valid_p});
    end
    total++;
    if (vec_w !== '0 || vec_s !== '0 || vec_p !== '0) begin
      bad++; $display("FAIL reset_out_vec: got %h/%h/%h required 0", vec_w, vec_s, vec_p);
    end
    total++;
    if ({row_w, row_s, row_p} !== 6'd0) begin
      bad++; $display("FAIL reset_out_row: got %0d required 0", row_w);
    end
    total++;
    if ({busy_w, busy_s, busy_p, done_w, done_s, done_p} !== 6'd0) begin
      bad++; $display("FAIL reset_busy_done: got %b required 000000",
                      {busy_w, busy_s, busy_p, done_w, done_s, done_p});
    end
    // in_valid while idle must not start anything.
    repeat (3) @(negedge clk);
    total++;
    if ({busy_w, in_ready_w} !== 2'b00) begin
      bad++; $display("FAIL idle_in_valid_ignored: busy/in_ready %b required 00", {busy_w, in_ready_w});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_identity();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < R; i++) a_m[t][i] = (i == t) ? 1 : 0;
      for (int j = 0; j < C; j++) b_m[t][j] = 4 * t + j + 1;
    end
    start_tile(4);
    feed(4, 0, -1);
    drain(0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < R; r++) begin
        total++;
        if (got_row[d][r] !== r) begin
          bad++; $display("FAIL identity_row dut%0d slot%0d: got %0d required %0d", d, r, got_row[d][r], r);
        end
        for (int j = 0; j < C; j++) begin
          total++;
          if (got[d][r][j] !== longint'(4 * r + j + 1)) begin
            bad++; $display("FAIL identity_val dut%0d C[%0d][%0d]: got %0d required %0d",
                            d, r, j, got[d][r][j], 4 * r + j + 1);
          end
        end
      end
    end
    total++;
    if (done_now !== 3'b111) begin
      bad++; $display("FAIL identity_done: got %b required 111", done_now);
    end
    @(negedge clk);
    total++;
    if ({done_w, done_s, done_p} !== 3'b000) begin
      bad++; $display("FAIL done_one_cycle: got %b required 000", {done_w, done_s, done_p});
    end
  endtask

  // One constant-operand tile; want[] is the expected element for each instance.
  task automatic const_tile(input string nm, input int k, input int av, input int bv,
                            input longint w0, input longint w1, input longint w2);
    longint want[3];
    want = '{w0, w1, w2};
    fill_const(k, av, bv);
    start_tile(k);
    feed(k, 0, -1);
    drain(0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < R; r++) begin
        for (int j = 0; j < C; j++) begin
          total++;
          if (got[d][r][j] !== want[d]) begin
            bad++; $display("FAIL %s dut%0d C[%0d][%0d]: got %0d required %0d",
                            nm, d, r, j, got[d][r][j], want[d]);
          end
        end
      end
    end
  endtask

  task automatic test_extremes();
    const_tile("extreme_nn", 4, -128, -128, 65536, 32767, 0);
    const_tile("extreme_np", 4, -128, 127, -65024, -32768, 512);
  endtask

  task automatic test_saturation();
    const_tile("saturation", 2, -128, -128, 32768, 32767, -32768);
  endtask

  task automatic test_bubbles();
    fill_random(4);
    start_tile(4);
    feed(4, 2, -1);
    drain(0, 1'b1);
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < R; r++) begin
        for (int j = 0; j < C; j++) begin
          total++;
          if (got[d][r][j] !== exp_d(d, r, j, 4)) begin
            bad++; $display("FAIL bubbles dut%0d C[%0d][%0d]: got %0d required %0d",
                            d, r, j, got[d][r][j], exp_d(d, r, j, 4));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int stall, cyc, order;
    fill_random(4);
    start_tile(4);
    feed(4, 0, -1);
    stall = 0;
    cyc = 0;
    order = 0;
    while (order < R && cyc < 200) begin
      if (out_valid_w && row_w == 2'd2 && stall < 5) begin
        out_ready = 1'b0;
        total++;
        if (row_w !== 2'd2) begin
          bad++; $display("FAIL stall_row: got %0d required 2", row_w);
        end
        for (int j = 0; j < C; j++) begin
          total++;
          if (get_elem(0, j) !== exp_d(0, 2, j, 4)) begin
            bad++; $display("FAIL stall_vec C[2][%0d] cycle %0d: got %0d required %0d",
                            j, stall, get_elem(0, j), exp_d(0, 2, j, 4));
          end
        end
        stall++;
      end else begin
        out_ready = 1'b1;
        if (out_valid_w) begin
          total++;
          if (int'(row_w) !== order) begin
            bad++; $display("FAIL stall_order: got row %0d required %0d", row_w, order);
          end
          for (int j = 0; j < C; j++) begin
            total++;
            if (get_elem(1, j) !== exp_d(1, order, j, 4)) begin
              bad++; $display("FAIL stall_sat C[%0d][%0d]: got %0d required %0d",
                              order, j, get_elem(1, j), exp_d(1, order, j, 4));
            end
          end
          order++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (order != R || stall != 5 || out_valid_w !== 1'b0) begin
      bad++; $display("FAIL stall_complete: rows %0d stalls %0d out_valid %b required 4 5 0",
                      order, stall, out_valid_w);
    end
  endtask

  task automatic test_control();
    // start during FEED must not restart or resize the tile
    fill_random(4);
    start_tile(4);
    feed(4, 0, 2);
    drain(0, 1'b0);
    for (int r = 0; r < R; r++) begin
      for (int j = 0; j < C; j++) begin
        total++;
        if (got[0][r][j] !== exp_d(0, r, j, 4)) begin
          bad++; $display("FAIL start_in_feed C[%0d][%0d]: got %0d required %0d",
                          r, j, got[0][r][j], exp_d(0, r, j, 4));
        end
      end
    end
    // k_len = 0 drains zeros straight away
    start_tile(0);
    total++;
    if ({in_ready_w, out_valid_w, busy_w} !== 3'b011) begin
      bad++; $display("FAIL k0_state: in_ready/out_valid/busy %b required 011",
                      {in_ready_w, out_valid_w, busy_w});
    end
    drain(1, 1'b1);
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < R; r++) begin
        total++;
        if (got_row[d][r] !== r) begin
          bad++; $display("FAIL k0_row dut%0d: got %0d required %0d", d, got_row[d][r], r);
        end
        for (int j = 0; j < C; j++) begin
          total++;
          if (got[d][r][j] !== 64'sd0) begin
            bad++; $display("FAIL k0_val dut%0d C[%0d][%0d]: got %0d required 0", d, r, j, got[d][r][j]);
          end
        end
      end
    end
    total++;
    if (done_now !== 3'b111) begin
      bad++; $display("FAIL k0_done: got %b required 111", done_now);
    end
  endtask

  task automatic test_reset_mid_flush();
    int seen;
    fill_random(3);
    start_tile(3);
    feed(3, 0, -1);
    @(negedge clk);
    total++;
    if ({busy_w, in_ready_w, out_valid_w} !== 3'b100) begin
      bad++; $display("FAIL flush_state: busy/in_ready/out_valid %b required 100",
                      {busy_w, in_ready_w, out_valid_w});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({busy_w, busy_s, busy_p, out_valid_w, in_ready_w} !== 5'b00000) begin
      bad++; $display("FAIL abort_state: busy x3/out_valid/in_ready %b required 00000",
                      {busy_w, busy_s, busy_p, out_valid_w, in_ready_w});
    end
    seen = 0;
    repeat (12) begin
      if (out_valid_w || done_w || busy_w) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_quiet: %0d active cycles, required 0", seen);
    end
    fill_random(5);
    start_tile(5);
    feed(5, 1, -1);
    drain(1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < R; r++) begin
        for (int j = 0; j < C; j++) begin
          total++;
          if (got[d][r][j] !== exp_d(d, r, j, 5)) begin
            bad++; $display("FAIL after_abort dut%0d C[%0d][%0d]: got %0d required %0d",
                            d, r, j, got[d][r][j], exp_d(d, r, j, 5));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // previous tile just drained: we sit in the done cycle
    total++;
    if (done_w !== 1'b1) begin
      bad++; $display("FAIL b2b_done: got %b required 1", done_w);
    end
    fill_random(2);
    start_tile(2);
    total++;
    if ({busy_w, in_ready_w} !== 2'b11) begin
      bad++; $display("FAIL b2b_start: busy/in_ready %b required 11", {busy_w, in_ready_w});
    end
    feed(2, 0, -1);
    drain(0, 1'b0);
    for (int r = 0; r < R; r++) begin
      for (int j = 0; j < C; j++) begin
        total++;
        if (got[2][r][j] !== exp_d(2, r, j, 2)) begin
          bad++; $display("FAIL b2b_val C[%0d][%0d]: got %0d required %0d",
                          r, j, got[2][r][j], exp_d(2, r, j, 2));
        end
      end
    end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(1, 64);
      fill_random(k);
      start_tile(k);
      feed(k, 1, -1);
      drain(1, 1'b1);
      for (int d = 0; d < 3; d++) begin
        for (int r = 0; r < R; r++) begin
          total++;
          if (got_row[d][r] !== r) begin
            bad++; $display("FAIL rand_row tile%0d dut%0d: got %0d required %0d", n, d, got_row[d][r], r);
          end
          for (int j = 0; j < C; j++) begin
            total++;
            if (got[d][r][j] !== exp_d(d, r, j, k)) begin
              bad++; $display("FAIL rand_val tile%0d dut%0d C[%0d][%0d]: got %0d required %0d",
                              n, d, r, j, got[d][r][j], exp_d(d, r, j, k));
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_saturation();
    test_bubbles();
    test_backpressure();
    test_control();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_os_array.md
Name: systolic_os_array

Overview:
- Parametrised output-stationary systolic array computing C = A x B over a streamed inner dimension K.
- Generalises the fixed 32x32 multiplier in three ways: configurable rows/cols/widths, valid/ready handshakes on input and output, and optional saturating accumulation.
- Placed between the SRAM read sequencer, which streams one A column and one B row per beat, and the post-processing/writeback stage, which drains C row by row.

Parameters:
- ROWS, 8, PE rows (M dimension); range 2..32.
- COLS, 8, PE columns (N dimension); range 2..32.
- DATA_W, 8, signed operand width.
- ACC_W, 2*DATA_W+8, signed accumulator width; must be >= 2*DATA_W.
- K_W, 10, width of the k_len field.
- SATURATE, 0, 1 = clamp accumulators to the signed ACC_W range; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  start a tile; honoured only in IDLE.
- k_len  in  K_W  beats in the tile; sampled when start is accepted.
- in_valid  in  1  a_vec/b_vec valid.
- in_ready  out  1  high only in FEED.
- a_vec  in  ROWS*DATA_W  A column; element i at [i*DATA_W +: DATA_W].
- b_vec  in  COLS*DATA_W  B row; element j at [j*DATA_W +: DATA_W].
- out_valid  out  1  out_vec holds C row out_row.
- out_ready  in  1  downstream accepts the row.
- out_vec  out  COLS*ACC_W  C[out_row][j] at [j*ACC_W +: ACC_W].
- out_row  out  $clog2(ROWS)  index of the row being presented.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all accumulators, skew registers and PE pipeline registers cleared to 0.
  - Outputs after reset: in_ready=0, out_valid=0, out_vec=0, out_row=0, busy=0, done=0.
  - Reset mid-tile aborts the tile immediately; no partial output and no done pulse.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - start=1 latches k_len, clears all accumulators to 0 and sets the beat counter to 0.
  - Next state is FEED; if k_len==0 the next state is DRAIN and all rows drain as zeros.
- FEED:
  - in_ready=1. Each cycle with in_valid=1 is an accepted beat; it injects a_vec/b_vec with a per-element valid bit.
  - Cycles with in_valid=0 inject bubbles (valid=0, data=0). The array advances every cycle regardless.
  - After the k_len-th accepted beat: next state FLUSH, in_ready drops the following cycle.
- Skew and propagation:
  - a element i passes through an i-stage delay line, then moves right one PE per cycle.
  - b element j passes through a j-stage delay line, then moves down one PE per cycle.
  - An operand pair accepted at cycle t is multiplied in PE(i,j) at cycle t+i+j+1 and lands in the accumulator at the edge ending that cycle.
  - A PE accumulates only when both arriving operand valids are 1. Bubbles never alter an accumulator.
- FLUSH: exactly ROWS+COLS-1 cycles, counted from the cycle after the last accepted beat. Then next state DRAIN.
- DRAIN:
  - out_valid=1, out_row starts at 0, out_vec shows accumulator row out_row.
  - out_valid && out_ready advances out_row. out_vec and out_row stay stable while out_ready=0.
  - The handshake on row ROWS-1 moves to IDLE and pulses done=1 for one cycle in that IDLE cycle.
  - Accumulators keep their values until the next accepted start.
- Arithmetic:
  - Product = signed DATA_W x signed DATA_W -> 2*DATA_W bits, sign-extended to ACC_W before adding.
  - SATURATE=1: sum above 2^(ACC_W-1)-1 clamps to that value; sum below -2^(ACC_W-1) clamps to that value; a clamped value keeps saturating on later beats.
  - SATURATE=0: two's-complement wrap.
- Boundaries:
  - start while busy=1 is ignored.
  - in_valid outside FEED is ignored; no beat is accepted.
  - start asserted in the same cycle as done is accepted, since done is asserted in IDLE.
  - Maximum k_len = 2^K_W-1 is legal.

Test Plan:
- Identity (ROWS=COLS=4, DATA_W=8, ACC_W=24, k_len=4): beats a=e_k, b=[1,2,3,4]+4k -> out_row r carries [4r+1..4r+4]; 4 rows then a done pulse.
- Signed extremes (k_len=4): all a=-128, b=-128 -> every C element = 65536. Repeat with a=-128, b=127 -> every element = -65024.
- Saturation (ACC_W=16, SATURATE=1, k_len=2): a=b=-128 -> every element = 32767. Same stimulus with SATURATE=0 -> -32768.
- Bubbles and backpressure: in_valid pattern 1,0,0,1,1,0,1 for k_len=4 gives results identical to a contiguous stream. out_ready low for 5 cycles on row 2 -> out_vec and out_row=2 held stable; no row skipped or repeated.
- Control: start during FEED ignored; k_len=0 -> ROWS zero rows then done. rst_n=0 in the middle of FLUSH -> IDLE next cycle, busy=0, no out_valid; the next tile's result is correct.
- Random: 200 tiles of random signed A/B (k_len 1..64), random in_valid/out_ready -> out_vec matches the reference model bit-exactly for both SATURATE settings.
